// File: rtl/bsg_link_upstream_sched_pkg.sv
// Shared types and sizing helpers for the upstream link scheduler.
package bsg_link_upstream_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    // Bits needed to hold a credit count from 0 up to credit_num inclusive.
    function automatic int unsigned credit_width(input int unsigned credit_num);
        return $clog2(credit_num + 1);
    endfunction

    // Largest packet length expressible in a len_width-bit length field.
    function automatic int unsigned max_len(input int unsigned len_width);
        return (2 ** len_width) - 1;
    endfunction

endpackage

// File: rtl/bsg_link_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i, wrapping.
module bsg_link_rr_pick
    import bsg_link_upstream_sched_pkg::*;
#(
    parameter int unsigned num_req_p   = 4,
    parameter int unsigned idx_width_p = 2
) (
    input  logic [num_req_p-1:0]   elig_i,
    input  logic [idx_width_p-1:0] rr_ptr_i,
    output logic [num_req_p-1:0]   pick_oh_o,
    output logic [idx_width_p-1:0] pick_idx_o,
    output logic                   any_v_o
);

    // Scan from the pointer forward and keep the first hit.
    always_comb begin
        logic        found;
        int unsigned idx;
        pick_oh_o  = '0;
        pick_idx_o = '0;
        any_v_o    = |elig_i;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned off = 0; off < num_req_p; off++) begin
            idx = (32'(rr_ptr_i) + off) % num_req_p;
            if (!found && elig_i[idx]) begin
                found          = 1'b1;
                pick_oh_o[idx] = 1'b1;
                pick_idx_o     = idx_width_p'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_link_upstream_sched.sv
// Credit-gated round-robin packet scheduler feeding the DDR upstream link core port.
module bsg_link_upstream_sched
    import bsg_link_upstream_sched_pkg::*;
#(
    parameter int unsigned num_req_p           = 4,
    parameter int unsigned width_p             = 64,
    parameter int unsigned credit_num_p        = 32,
    parameter int unsigned credits_per_token_p = 8,
    parameter int unsigned len_width_p         = 4
) (
    input  logic                                 core_clk_i,
    input  logic                                 core_reset_n_i,
    input  logic                                 en_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p*len_width_p-1:0]     req_len_i,
    input  logic [num_req_p*width_p-1:0]         req_data_i,
    output logic [num_req_p-1:0]                 req_yumi_o,
    output logic                                 link_v_o,
    output logic [width_p-1:0]                   link_data_o,
    input  logic                                 link_ready_i,
    input  logic                                 token_i,
    output logic [num_req_p-1:0]                 grant_o,
    output logic                                 busy_o,
    output logic [$clog2(credit_num_p+1)-1:0]    credit_o,
    output logic                                 err_o
);

    localparam int unsigned IdxW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned CredW = credit_width(credit_num_p);
    localparam int unsigned RemW  = $clog2(max_len(len_width_p) + 1);

    sched_state_e            state_q, state_d;
    logic [num_req_p-1:0]    grant_q, grant_d;
    logic [IdxW-1:0]         gnt_idx_q, gnt_idx_d;
    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [RemW-1:0]         remaining_q, remaining_d;
    logic [CredW-1:0]        credit_q, credit_d;
    logic                    err_q, err_d;

    logic [len_width_p-1:0]  len_eff [num_req_p];
    logic [width_p-1:0]      data_arr [num_req_p];
    logic [num_req_p-1:0]    elig;
    logic [num_req_p-1:0]    pick_oh;
    logic [IdxW-1:0]         pick_idx;
    logic                    pick_any;
    logic                    yumi;
    logic [31:0]             credit_sum;

    // Unpack requester buses; a zero length counts as a single flit, then test credit cover.
    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            len_eff[i]  = req_len_i[i*len_width_p +: len_width_p];
            if (len_eff[i] == '0) begin
                len_eff[i] = len_width_p'(1);
            end
            data_arr[i] = req_data_i[i*width_p +: width_p];
            elig[i]     = req_v_i[i] && (32'(len_eff[i]) <= 32'(credit_q));
        end
    end

    bsg_link_rr_pick #(
        .num_req_p  (num_req_p),
        .idx_width_p(IdxW)
    ) u_pick (
        .elig_i    (elig),
        .rr_ptr_i  (rr_ptr_q),
        .pick_oh_o (pick_oh),
        .pick_idx_o(pick_idx),
        .any_v_o   (pick_any)
    );

    // Next-state and link-side outputs: arbitrate in IDLE, stream the owner's flits in SEND.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        link_v_o    = 1'b0;
        link_data_o = '0;
        req_yumi_o  = '0;
        yumi        = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && pick_any) begin
                    state_d     = SEND;
                    grant_d     = pick_oh;
                    gnt_idx_d   = pick_idx;
                    remaining_d = RemW'(len_eff[pick_idx]);
                end
            end
            SEND: begin
                link_v_o    = req_v_i[gnt_idx_q];
                link_data_o = data_arr[gnt_idx_q];
                yumi        = link_v_o & link_ready_i;
                req_yumi_o  = yumi ? grant_q : '0;
                if (yumi) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == RemW'(1)) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (gnt_idx_q == IdxW'(num_req_p - 1)) ? '0 : gnt_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credit window: consume one per accepted flit, refill per token, saturate and flag overflow.
    always_comb begin
        credit_sum = 32'(credit_q) + (token_i ? 32'(credits_per_token_p) : 32'd0) - 32'(yumi);
        credit_d   = CredW'(credit_sum);
        err_d      = err_q;
        if (credit_sum > 32'(credit_num_p)) begin
            credit_d = CredW'(credit_num_p);
            err_d    = 1'b1;
        end
    end

    // State registers; reset drops any in-flight packet.
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            credit_q    <= CredW'(credit_num_p);
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

    assign grant_o  = grant_q;
    assign busy_o   = (state_q == SEND);
    assign credit_o = credit_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
// Directed bench for the upstream link scheduler with hand-computed expectations.
module tb_bsg_link_upstream_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 64;
    localparam int unsigned CN = 32;
    localparam int unsigned LW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req_v;
    logic [N*LW-1:0] req_len;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   yumi;
    logic           link_v;
    logic [W-1:0]   link_data;
    logic           ready;
    logic           token;
    logic [N-1:0]   grant;
    logic           busy;
    logic [5:0]     credit;
    logic           err;

    int checks   = 0;
    int failures = 0;

    bsg_link_upstream_sched #(
        .num_req_p          (N),
        .width_p            (W),
        .credit_num_p       (CN),
        .credits_per_token_p(8),
        .len_width_p        (LW)
    ) dut (
        .core_clk_i    (clk),
        .core_reset_n_i(rst_n),
        .en_i          (en),
        .req_v_i       (req_v),
        .req_len_i     (req_len),
        .req_data_i    (req_data),
        .req_yumi_o    (yumi),
        .link_v_o      (link_v),
        .link_data_o   (link_data),
        .link_ready_i  (ready),
        .token_i       (token),
        .grant_o       (grant),
        .busy_o        (busy),
        .credit_o      (credit),
        .err_o         (err)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] datum(input int i);
        return 64'h1111_2222_0000_0000 + 64'(i * 3 + 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int len);
        req_v[i]            = v;
        req_len[i*LW +: LW] = LW'(len);
    endtask

    // Send one whole packet from requester idx, which must be the next pick.
    task automatic run_pkt(input int idx, input int len);
        set_req(idx, 1'b1, len);
        tick();
        check_eq("pkt_grant", 64'(grant), 64'(1 << idx));
        repeat (len) tick();
        set_req(idx, 1'b0, len);
        #1;
        check_eq("pkt_done_busy", 64'(busy), 64'd0);
    endtask

    // Credit must never exceed the window (a wrap would show up as a large value).
    always @(negedge clk) begin
        if (rst_n === 1'b1) check_eq("credit_bound", 64'(credit <= 6'(CN)), 64'd1);
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        ready    = 1'b1;
        token    = 1'b0;
        req_v    = '0;
        req_len  = '0;
        for (int i = 0; i < int'(N); i++) req_data[i*W +: W] = datum(i);
        #12;
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_credit", 64'(credit), 64'd32);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single 3-flit packet from req0
        set_req(0, 1'b1, 3);
        #1;
        check_eq("t1_idle_grant", 64'(grant), 64'd0);
        check_eq("t1_idle_v", 64'(link_v), 64'd0);
        tick();
        check_eq("t1_grant", 64'(grant), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd1);
        check_eq("t1_v", 64'(link_v), 64'd1);
        check_eq("t1_data", link_data, datum(0));
        check_eq("t1_yumi", 64'(yumi), 64'd1);
        check_eq("t1_credit0", 64'(credit), 64'd32);
        tick();
        check_eq("t1_credit1", 64'(credit), 64'd31);
        tick();
        check_eq("t1_credit2", 64'(credit), 64'd30);
        tick();
        check_eq("t1_credit3", 64'(credit), 64'd29);
        check_eq("t1_end_grant", 64'(grant), 64'd0);
        check_eq("t1_end_data", link_data, 64'd0);
        set_req(0, 1'b0, 3);

        // all requesters single-flit (req3 with len 0) -> rotating grants from rr_ptr=1
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1);
        set_req(3, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t2_grant", 64'(grant), 64'(1 << ((1 + k) % 4)));
            check_eq("t2_data", link_data, datum((1 + k) % 4));
            tick();
            check_eq("t2_bubble", 64'(grant), 64'd0);
        end
        check_eq("t2_credit", 64'(credit), 64'd24);
        req_v = '0;

        // drain to credit=4 with rr_ptr=1, then skip ineligible req1
        run_pkt(0, 15);
        run_pkt(0, 5);
        check_eq("t3_credit4", 64'(credit), 64'd4);
        set_req(1, 1'b1, 6);
        set_req(2, 1'b1, 2);
        tick();
        check_eq("t3_grant2", 64'(grant), 64'b0100);
        tick();
        tick();
        check_eq("t3_credit2", 64'(credit), 64'd2);
        set_req(2, 1'b0, 2);
        tick();
        check_eq("t3_starved", 64'(grant), 64'd0);
        token = 1'b1;
        tick();
        token = 1'b0;
        check_eq("t3_token", 64'(credit), 64'd10);
        tick();
        check_eq("t3_grant1", 64'(grant), 64'b0010);

        // stalls: link not ready, then requester drops valid
        ready = 1'b0;
        repeat (3) begin
            tick();
            check_eq("t4_ready_yumi", 64'(yumi), 64'd0);
            check_eq("t4_ready_grant", 64'(grant), 64'b0010);
            check_eq("t4_ready_credit", 64'(credit), 64'd10);
        end
        ready    = 1'b1;
        req_v[1] = 1'b0;
        repeat (2) begin
            tick();
            check_eq("t4_drop_v", 64'(link_v), 64'd0);
            check_eq("t4_drop_yumi", 64'(yumi), 64'd0);
            check_eq("t4_drop_grant", 64'(grant), 64'b0010);
        end
        req_v[1] = 1'b1;
        #1;
        check_eq("t4_resume_yumi", 64'(yumi), 64'b0010);
        repeat (5) tick();
        check_eq("t4_credit5", 64'(credit), 64'd5);
        check_eq("t4_still_busy", 64'(busy), 64'd1);
        tick();
        check_eq("t4_credit4", 64'(credit), 64'd4);
        check_eq("t4_done", 64'(busy), 64'd0);
        set_req(1, 1'b0, 6);

        // token plus yumi at credit 30 saturates and latches err
        token = 1'b1;
        repeat (3) tick();
        token = 1'b0;
        check_eq("t5_credit28", 64'(credit), 64'd28);
        check_eq("t5_err0", 64'(err), 64'd0);
        run_pkt(2, 6);
        token = 1'b1;
        tick();
        token = 1'b0;
        check_eq("t5_credit30", 64'(credit), 64'd30);
        set_req(3, 1'b1, 2);
        tick();
        check_eq("t5_grant3", 64'(grant), 64'b1000);
        token = 1'b1;
        tick();
        token = 1'b0;
        check_eq("t5_sat", 64'(credit), 64'd32);
        check_eq("t5_err", 64'(err), 64'd1);
        tick();
        check_eq("t5_credit31", 64'(credit), 64'd31);
        check_eq("t5_err_sticky", 64'(err), 64'd1);
        set_req(3, 1'b0, 2);

        // reset mid-packet, then rr_ptr restarts at 0
        run_pkt(1, 1);
        set_req(2, 1'b1, 4);
        tick();
        check_eq("t6_grant2", 64'(grant), 64'b0100);
        tick();
        check_eq("t6_credit29", 64'(credit), 64'd29);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_grant", 64'(grant), 64'd0);
        check_eq("t6_rst_busy", 64'(busy), 64'd0);
        check_eq("t6_rst_v", 64'(link_v), 64'd0);
        check_eq("t6_rst_yumi", 64'(yumi), 64'd0);
        check_eq("t6_rst_credit", 64'(credit), 64'd32);
        check_eq("t6_rst_err", 64'(err), 64'd0);
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 1);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_en_gate", 64'(grant), 64'd0);
        en = 1'b1;
        tick();
        check_eq("t6_first_grant", 64'(grant), 64'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
